// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encodings, row reset pattern,
// board legend key codes and a lowest-low-bit helper.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Board legend: key_code = row*4 + col
  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  // Index of the lowest-numbered zero bit; serves both column priority and row index.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) first_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running enable-pulse divider: tick is high for one clk every 2^SCAN_EXP clks.
module scan_tick_gen #(
  parameter int SCAN_EXP = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [SCAN_EXP-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign tick = &div_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronised column sampling,
// debounced press/release with a one-clk key_valid pulse and a held key_down level.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_EXP   = 16,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [2:0] CNT_DONE = 3'(DEBOUNCE_N);

  logic       tick;
  logic [3:0] col_meta_q, col_sync_q;
  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic       col_hit;
  logic [2:0] cnt_inc;
  logic [3:0] row_next;

  scan_tick_gen #(.SCAN_EXP(SCAN_EXP)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    col_hit     = ~col_sync_q[col_idx_q];
    cnt_inc     = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
    row_next    = {row_q[2:0], row_q[3]};

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_sync_q != 4'hF) begin
            row_idx_d = first_low(row_q);
            col_idx_d = first_low(col_sync_q);
            cnt_d     = 3'd1;
            state_d   = DB_PRESS;
          end else begin
            row_d = row_next;
          end
        end
        DB_PRESS: begin
          if (col_hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = HELD;
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_next;
          end
        end
        // Row stays frozen here, so keys on other rows are invisible (no rollover).
        HELD: begin
          if (!col_hit) begin
            cnt_d   = 3'd1;
            state_d = DB_REL;
          end
        end
        DB_REL: begin
          if (!col_hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              key_down_d = 1'b0;
              state_d    = SCAN;
              row_d      = row_next;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= ROW_RESET;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      cnt_q       <= 3'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_out   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad and an abstract scan/debounce model.
module tb_keypad_scan;

  localparam int SCAN_EXP = 3;
  localparam int DEB      = 4;
  localparam int PERIOD   = 1 << SCAN_EXP;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  keypad_scan #(.SCAN_EXP(SCAN_EXP), .DEBOUNCE_N(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its column low only while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // Abstract model: which row is scanned, whether the scan is parked on a key,
  // how many consecutive ticks the key has looked closed / open.
  int         m_div    = 0;
  logic [3:0] m_s1     = 4'hF;
  logic [3:0] m_s2     = 4'hF;
  int         m_row    = 0;
  bit         m_parked = 0;
  bit         m_down   = 0;
  int         m_closed = 0;
  int         m_open   = 0;
  int         m_col    = 0;
  logic [3:0] m_code   = 4'd0;
  bit         m_valid  = 0;

  function automatic int lowest_zero(input logic [3:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (!v[i]) r = i;
    return r;
  endfunction

  task automatic model_tick(input logic [3:0] c);
    if (!m_parked) begin
      if (c != 4'hF) begin
        m_parked = 1;
        m_col    = lowest_zero(c);
        m_closed = 1;
      end else begin
        m_row = (m_row + 1) % 4;
      end
    end else if (!m_down) begin
      if (!c[m_col]) begin
        m_closed++;
        if (m_closed == DEB) begin
          m_down  = 1;
          m_valid = 1;
          m_code  = 4'(m_row * 4 + m_col);
          m_open  = 0;
        end
      end else begin
        m_parked = 0;
        m_row    = (m_row + 1) % 4;
      end
    end else begin
      if (c[m_col]) begin
        m_open++;
        if (m_open == DEB) begin
          m_down   = 0;
          m_parked = 0;
          m_open   = 0;
          m_row    = (m_row + 1) % 4;
        end
      end else begin
        m_open = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_div = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_row = 0; m_parked = 0;
        m_down = 0; m_closed = 0; m_open = 0; m_col = 0; m_code = 4'd0; m_valid = 0;
      end else begin
        m_valid = 0;
        if (m_div == PERIOD - 1) model_tick(m_s2);
        m_div = (m_div + 1) % PERIOD;
        m_s2  = m_s1;
        m_s1  = col_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("row_out", row_out, ~(32'd1 << m_row) & 32'hF);
      check("key_code", key_code, m_code);
      check("key_valid", key_valid, m_valid);
      check("key_down", key_down, m_down);
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic wait_row(input logic [3:0] target);
    logic [3:0] prev;
    bit found = 0;
    prev = row_out;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (row_out == target && prev != target) found = 1;
      prev = row_out;
    end
    if (!found) check("wait_row_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (key_valid) found = 1;
    end
    if (!found) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"}, row_out, 4'b1110);
    check({tag, "_code"}, key_code, 4'd0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_down"}, key_down, 1'b0);
  endtask

  int base;

  initial begin
    // 1: reset state and rotation
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check("rot_hold", row_out, 4'b1110);
    @(negedge clk);
    check("rot_step", row_out, 4'b1101);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mid_reset_row", row_out, 4'b1110);
    @(negedge clk);
    reset = 1'b0;

    // 2: press (2,1) for 12 ticks, then release
    wait_row(4'b1011);
    base = pulses;
    pressed[9] = 1'b1;
    repeat (96) @(negedge clk);
    check("press_pulses", pulses - base, 1);
    check("press_code", key_code, 4'd9);
    check("press_down", key_down, 1'b1);
    check("press_row_frozen", row_out, 4'b1011);
    pressed[9] = 1'b0;
    repeat (40) @(negedge clk);
    check("release_down", key_down, 1'b0);
    check("release_pulses", pulses - base, 1);

    // 3: press bounce on (1,3)
    wait_row(4'b1101);
    base = pulses;
    pressed[7] = 1'b1;
    repeat (20) @(negedge clk);
    pressed[7] = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_row_next", row_out, 4'b1011);
    repeat (36) @(negedge clk);
    check("bounce_pulses", pulses - base, 0);
    check("bounce_code", key_code, 4'd9);

    // 4: release bounce on (0,0)
    wait_row(4'b1110);
    base = pulses;
    pressed[0] = 1'b1;
    wait_valid();
    repeat (8) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (20) @(negedge clk);
    pressed[0] = 1'b1;
    repeat (16) @(negedge clk);
    check("relbounce_down", key_down, 1'b1);
    check("relbounce_pulses", pulses - base, 1);
    check("relbounce_code", key_code, 4'd0);
    pressed[0] = 1'b0;
    repeat (48) @(negedge clk);
    check("relbounce_final_down", key_down, 1'b0);

    // 5: simultaneous (3,0)+(3,3), then (0,2) while held
    wait_row(4'b0111);
    pressed[12] = 1'b1;
    pressed[15] = 1'b1;
    wait_valid();
    check("multi_code", key_code, 4'd12);
    repeat (2) @(negedge clk);
    base = pulses;
    pressed[2] = 1'b1;
    repeat (64) @(negedge clk);
    check("rollover_pulses", pulses - base, 0);
    check("rollover_row", row_out, 4'b0111);
    check("rollover_code", key_code, 4'd12);
    check("rollover_down", key_down, 1'b1);
    pressed = '0;
    repeat (64) @(negedge clk);
    check("multi_release_down", key_down, 1'b0);

    // 6: reset during debounce and during held, then a fresh press
    wait_row(4'b1011);
    base = pulses;
    pressed[9] = 1'b1;
    repeat (12) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_dbpress");
    @(negedge clk);
    pressed = '0;
    reset = 1'b0;
    repeat (64) @(negedge clk);
    check("rst_dbpress_pulses", pulses - base, 0);

    wait_row(4'b1011);
    pressed[9] = 1'b1;
    wait_valid();
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_held");
    base = pulses;
    @(negedge clk);
    pressed = '0;
    reset = 1'b0;
    repeat (64) @(negedge clk);
    check("rst_held_pulses", pulses - base, 0);

    wait_row(4'b1101);
    base = pulses;
    pressed[5] = 1'b1;
    wait_valid();
    check("fresh_code", key_code, 4'd5);
    check("fresh_down", key_down, 1'b1);
    pressed = '0;
    repeat (64) @(negedge clk);
    check("fresh_pulses", pulses - base, 1);
    check("fresh_release", key_down, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
